// File: rtl/spm_dp_param_if.sv
// One scratchpad access port: address strobe, direction, byte enables and data.
// The requester drives the master side; the scratchpad implements the slave side.
interface spm_dp_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 12
);
    logic [ADDR_W-1:0]   spm_addr;
    logic                spm_as_;
    logic                spm_rw;
    logic [DATA_W/8-1:0] spm_be;
    logic [DATA_W-1:0]   spm_wr_data;
    logic [DATA_W-1:0]   spm_rd_data;

    modport master (
        output spm_addr,
        output spm_as_,
        output spm_rw,
        output spm_be,
        output spm_wr_data,
        input  spm_rd_data
    );

    modport slave (
        input  spm_addr,
        input  spm_as_,
        input  spm_rw,
        input  spm_be,
        input  spm_wr_data,
        output spm_rd_data
    );
endinterface

// File: rtl/spm_dp_param.sv
// Dual-port scratchpad (IF and MEM ports) with byte-lane writes, registered reads,
// cross-port write-first forwarding, MEM-wins collision merge and optional clear after reset.
module spm_dp_param #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_,
    spm_dp_param_if.slave        if_spm,
    spm_dp_param_if.slave        mem_spm,
    output logic                 spm_busy,
    output logic                 spm_collision
);
    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [LANES-1:0]  be_t;
    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e state_q, state_d;
    addr_t  clr_addr_q, clr_addr_d;
    word_t  mem [DEPTH];

    word_t  if_rd_q, if_rd_d, mem_rd_q, mem_rd_d;
    logic   coll_q, coll_d;

    logic   run, if_wr, if_rd, mem_wr, mem_rd, same_addr;
    word_t  if_old, mem_old, if_wword, mem_wword;

    function automatic word_t merge(input word_t old, input word_t nw, input be_t be);
        word_t res;
        res = old;
        for (int i = 0; i < int'(LANES); i++) begin
            if (be[i]) res[i*8 +: 8] = nw[i*8 +: 8];
        end
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StClear: begin
                clr_addr_d = clr_addr_q + addr_t'(1);
                if (clr_addr_q == '1) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    assign run       = (state_q == StRun);
    assign if_wr     = run && !if_spm.spm_as_ && !if_spm.spm_rw;
    assign if_rd     = run && !if_spm.spm_as_ &&  if_spm.spm_rw;
    assign mem_wr    = run && !mem_spm.spm_as_ && !mem_spm.spm_rw;
    assign mem_rd    = run && !mem_spm.spm_as_ &&  mem_spm.spm_rw;
    assign same_addr = (if_spm.spm_addr == mem_spm.spm_addr);

    assign if_old  = mem[if_spm.spm_addr];
    assign mem_old = mem[mem_spm.spm_addr];

    // MEM merges on top of IF's lanes when both hit one word, so MEM wins overlaps.
    assign if_wword  = merge(if_old, if_spm.spm_wr_data, if_spm.spm_be);
    assign mem_wword = merge((if_wr && same_addr) ? if_wword : mem_old,
                             mem_spm.spm_wr_data, mem_spm.spm_be);

    always_comb begin
        if_rd_d  = if_rd_q;
        mem_rd_d = mem_rd_q;
        coll_d   = if_wr && mem_wr && same_addr;
        if (if_rd)  if_rd_d  = (mem_wr && same_addr) ? mem_wword : if_old;
        if (mem_rd) mem_rd_d = (if_wr && same_addr) ? if_wword : mem_old;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= CLEAR_ON_RESET ? StClear : StRun;
            clr_addr_q <= '0;
            if_rd_q    <= '0;
            mem_rd_q   <= '0;
            coll_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            if_rd_q    <= if_rd_d;
            mem_rd_q   <= mem_rd_d;
            coll_q     <= coll_d;
        end
    end

    // Storage has no reset; the clear sequence initialises it when enabled.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[clr_addr_q] <= '0;
        end else begin
            if (if_wr)  mem[if_spm.spm_addr]  <= if_wword;
            if (mem_wr) mem[mem_spm.spm_addr] <= mem_wword;
        end
    end

    assign if_spm.spm_rd_data  = if_rd_q;
    assign mem_spm.spm_rd_data = mem_rd_q;
    assign spm_busy            = (state_q == StClear);
    assign spm_collision       = coll_q;
endmodule

// File: tb/tb_spm_dp_param.sv
// Directed bench for spm_dp_param: DUT a clears on reset, DUT b does not.
module tb_spm_dp_param;
    logic clk = 1'b0;
    logic reset_a, reset_b;
    logic busy_a, coll_a, busy_b, coll_b;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n;

    always #5 clk = ~clk;

    spm_dp_param_if #(.DATA_W(32), .ADDR_W(4)) a_if  ();
    spm_dp_param_if #(.DATA_W(32), .ADDR_W(4)) a_mem ();
    spm_dp_param_if #(.DATA_W(32), .ADDR_W(4)) b_if  ();
    spm_dp_param_if #(.DATA_W(32), .ADDR_W(4)) b_mem ();

    spm_dp_param #(.DATA_W(32), .ADDR_W(4), .CLEAR_ON_RESET(1'b1)) u_dut_a (
        .clk           (clk),
        .reset_        (reset_a),
        .if_spm        (a_if),
        .mem_spm       (a_mem),
        .spm_busy      (busy_a),
        .spm_collision (coll_a)
    );

    spm_dp_param #(.DATA_W(32), .ADDR_W(4), .CLEAR_ON_RESET(1'b0)) u_dut_b (
        .clk           (clk),
        .reset_        (reset_b),
        .if_spm        (b_if),
        .mem_spm       (b_mem),
        .spm_busy      (busy_b),
        .spm_collision (coll_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // as_ active low; rw 1=read 0=write
    task automatic a_if_drv(input logic as_, input logic rw, input logic [3:0] addr,
                            input logic [3:0] be, input logic [31:0] d);
        a_if.spm_as_ = as_; a_if.spm_rw = rw; a_if.spm_addr = addr;
        a_if.spm_be = be; a_if.spm_wr_data = d;
    endtask

    task automatic a_mem_drv(input logic as_, input logic rw, input logic [3:0] addr,
                             input logic [3:0] be, input logic [31:0] d);
        a_mem.spm_as_ = as_; a_mem.spm_rw = rw; a_mem.spm_addr = addr;
        a_mem.spm_be = be; a_mem.spm_wr_data = d;
    endtask

    task automatic b_if_drv(input logic as_, input logic rw, input logic [3:0] addr,
                            input logic [3:0] be, input logic [31:0] d);
        b_if.spm_as_ = as_; b_if.spm_rw = rw; b_if.spm_addr = addr;
        b_if.spm_be = be; b_if.spm_wr_data = d;
    endtask

    task automatic b_mem_drv(input logic as_, input logic rw, input logic [3:0] addr,
                             input logic [3:0] be, input logic [31:0] d);
        b_mem.spm_as_ = as_; b_mem.spm_rw = rw; b_mem.spm_addr = addr;
        b_mem.spm_be = be; b_mem.spm_wr_data = d;
    endtask

    task automatic a_idle();
        a_if_drv(1'b1, 1'b1, 4'h0, 4'h0, 32'h0);
        a_mem_drv(1'b1, 1'b1, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic b_idle();
        b_if_drv(1'b1, 1'b1, 4'h0, 4'h0, 32'h0);
        b_mem_drv(1'b1, 1'b1, 4'h0, 4'h0, 32'h0);
    endtask

    initial begin
        reset_a = 1'b0;
        reset_b = 1'b0;
        a_idle();
        b_idle();
        #12;
        check("reset_if_rd", a_if.spm_rd_data, 32'h0);
        check("reset_mem_rd", a_mem.spm_rd_data, 32'h0);
        check("reset_busy_a", busy_a, 1'b1);
        check("reset_coll_a", coll_a, 1'b0);
        check("reset_busy_b", busy_b, 1'b0);

        // T1: clear length, then everything reads zero
        step();
        reset_a = 1'b1;
        n = 0;
        while (busy_a && n < 40) begin
            step();
            n++;
        end
        check("clear_cycles", n, 16);
        for (int a = 0; a < 16; a++) begin
            a_if_drv(1'b0, 1'b1, 4'(a), 4'h0, 32'h0);
            a_mem_drv(1'b0, 1'b1, 4'(15 - a), 4'h0, 32'h0);
            step();
            check("t1_if_zero", a_if.spm_rd_data, 32'h0);
            check("t1_mem_zero", a_mem.spm_rd_data, 32'h0);
        end
        a_idle();

        // T2: MEM write then IF read
        a_mem_drv(1'b0, 1'b0, 4'd5, 4'hF, 32'hDEADBEEF);
        step();
        a_mem_drv(1'b1, 1'b1, 4'd0, 4'h0, 32'h0);
        a_if_drv(1'b0, 1'b1, 4'd5, 4'h0, 32'h0);
        step();
        check("t2_if_rd", a_if.spm_rd_data, 32'hDEADBEEF);
        a_idle();
        step();
        check("t2_hold", a_if.spm_rd_data, 32'hDEADBEEF);

        // T3: double write, overlapping lanes
        a_mem_drv(1'b0, 1'b0, 4'd7, 4'hF, 32'h11223344);
        step();
        check("t3_no_coll", coll_a, 1'b0);
        a_if_drv(1'b0, 1'b0, 4'd7, 4'b0011, 32'hAAAAAAAA);
        a_mem_drv(1'b0, 1'b0, 4'd7, 4'b0110, 32'hBBBBBBBB);
        step();
        check("t3_coll", coll_a, 1'b1);
        a_idle();
        a_if_drv(1'b0, 1'b1, 4'd7, 4'h0, 32'h0);
        step();
        check("t3_coll_pulse", coll_a, 1'b0);
        check("t3_merge", a_if.spm_rd_data, 32'h11BBBBAA);

        // Collision with disjoint lanes, and no collision on different addresses
        a_if_drv(1'b0, 1'b0, 4'd3, 4'b0001, 32'h000000AA);
        a_mem_drv(1'b0, 1'b0, 4'd3, 4'b0010, 32'h0000BB00);
        step();
        check("coll_disjoint", coll_a, 1'b1);
        a_if_drv(1'b0, 1'b0, 4'd4, 4'hF, 32'h44444444);
        a_mem_drv(1'b0, 1'b0, 4'd6, 4'hF, 32'h66666666);
        step();
        check("coll_diff_addr", coll_a, 1'b0);
        a_if_drv(1'b0, 1'b1, 4'd3, 4'h0, 32'h0);
        a_mem_drv(1'b0, 1'b1, 4'd4, 4'h0, 32'h0);
        step();
        check("disjoint_merge", a_if.spm_rd_data, 32'h0000BBAA);
        check("diff_addr_wr", a_mem.spm_rd_data, 32'h44444444);

        // T4: write-first forwarding in both directions
        a_idle();
        a_mem_drv(1'b0, 1'b0, 4'd9, 4'hF, 32'h0);
        step();
        a_mem_drv(1'b0, 1'b0, 4'd9, 4'b0001, 32'h000000FF);
        a_if_drv(1'b0, 1'b1, 4'd9, 4'h0, 32'h0);
        step();
        check("t4_fwd_mem_to_if", a_if.spm_rd_data, 32'h000000FF);
        a_if_drv(1'b0, 1'b0, 4'd9, 4'b0010, 32'h0000AB00);
        a_mem_drv(1'b0, 1'b1, 4'd9, 4'h0, 32'h0);
        step();
        check("t4_fwd_if_to_mem", a_mem.spm_rd_data, 32'h0000ABFF);

        // be=0 write is a no-op
        a_if_drv(1'b1, 1'b1, 4'd0, 4'h0, 32'h0);
        a_mem_drv(1'b0, 1'b0, 4'd9, 4'h0, 32'h12121212);
        step();
        a_mem_drv(1'b0, 1'b1, 4'd9, 4'h0, 32'h0);
        step();
        check("be_zero_noop", a_mem.spm_rd_data, 32'h0000ABFF);

        // T5: reset during reads
        a_mem_drv(1'b0, 1'b0, 4'd2, 4'hF, 32'h12345678);
        step();
        a_mem_drv(1'b0, 1'b1, 4'd2, 4'h0, 32'h0);
        a_if_drv(1'b0, 1'b1, 4'd2, 4'h0, 32'h0);
        step();
        check("t5_pre_if", a_if.spm_rd_data, 32'h12345678);
        check("t5_pre_mem", a_mem.spm_rd_data, 32'h12345678);
        #2;
        reset_a = 1'b0;
        #1;
        check("t5_async_if", a_if.spm_rd_data, 32'h0);
        check("t5_async_mem", a_mem.spm_rd_data, 32'h0);
        check("t5_busy", busy_a, 1'b1);
        // Accesses held throughout busy must not take effect
        a_mem_drv(1'b0, 1'b0, 4'd0, 4'hF, 32'hFFFFFFFF);
        step();
        step();
        reset_a = 1'b1;
        n = 0;
        while (busy_a && n < 40) begin
            step();
            n++;
        end
        check("t5_clear_cycles", n, 16);
        check("t5_busy_if_rd", a_if.spm_rd_data, 32'h0);
        a_idle();
        a_if_drv(1'b0, 1'b1, 4'd0, 4'h0, 32'h0);
        a_mem_drv(1'b0, 1'b1, 4'd2, 4'h0, 32'h0);
        step();
        check("t5_addr0", a_if.spm_rd_data, 32'h0);
        check("t5_addr2", a_mem.spm_rd_data, 32'h0);
        a_idle();

        // T6: no clear, write lands in the first cycle after reset
        reset_b = 1'b1;
        b_mem_drv(1'b0, 1'b0, 4'd3, 4'hF, 32'hCAFEF00D);
        step();
        check("t6_busy", busy_b, 1'b0);
        b_mem_drv(1'b1, 1'b1, 4'd0, 4'h0, 32'h0);
        b_if_drv(1'b0, 1'b1, 4'd3, 4'h0, 32'h0);
        step();
        check("t6_first_wr", b_if.spm_rd_data, 32'hCAFEF00D);
        b_idle();
        b_if_drv(1'b0, 1'b0, 4'd3, 4'b1000, 32'h5A000000);
        step();
        b_if_drv(1'b1, 1'b1, 4'd0, 4'h0, 32'h0);
        b_mem_drv(1'b0, 1'b1, 4'd3, 4'h0, 32'h0);
        step();
        check("t6_lane_wr", b_mem.spm_rd_data, 32'h5AFEF00D);
        b_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
